// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with a prescaler, PWM brightness per digit slot,
// and double-buffered digit data that only changes at a frame boundary.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 16,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [DIV_W-1:0]        div_period,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [6:0]              SegOut,
  output logic                    DpOut,
  output logic [NUM_DIGITS-1:0]   AnOut,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'b1000000;
      4'h1: hex2seg = 7'b1111001;
      4'h2: hex2seg = 7'b0100100;
      4'h3: hex2seg = 7'b0110000;
      4'h4: hex2seg = 7'b0011001;
      4'h5: hex2seg = 7'b0010010;
      4'h6: hex2seg = 7'b0000010;
      4'h7: hex2seg = 7'b1111000;
      4'h8: hex2seg = 7'b0000000;
      4'h9: hex2seg = 7'b0010000;
      4'hA: hex2seg = 7'b0001000;
      4'hB: hex2seg = 7'b0000011;
      4'hC: hex2seg = 7'b1000110;
      4'hD: hex2seg = 7'b0100001;
      4'hE: hex2seg = 7'b0000110;
      default: hex2seg = 7'b0001110;
    endcase
  endfunction

  logic [DIV_W-1:0]                presc_q, presc_d;
  logic [BRIGHT_W-1:0]             slot_q, slot_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0][3:0]      pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
  logic [NUM_DIGITS-1:0]           pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]           pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
  logic [6:0]                      seg_q, seg_d;
  logic                            dp_q, dp_d;
  logic [NUM_DIGITS-1:0]           an_q, an_d;
  logic                            frame_done_q, frame_done_d;

  logic                            tick, slot_wrap, frame_wrap, an_on;
  logic [NUM_DIGITS-1:0]           an_sel;

  // One select line per digit; at most one can be high since idx_q is a single index.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_an
    assign an_sel[i] = an_on && (idx_q == IDX_W'(i));
  end

  always_comb begin
    tick       = (presc_q >= div_period);
    presc_d    = tick ? '0 : presc_q + 1'b1;
    slot_wrap  = tick && (slot_q == '1);
    slot_d     = tick ? slot_q + 1'b1 : slot_q;
    frame_wrap = slot_wrap && (idx_q == LAST_IDX);
    idx_d      = idx_q;
    if (slot_wrap) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    frame_done_d = frame_wrap;

    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    if (load) begin
      pend_dig_d   = digits;
      pend_dp_d    = dp_in;
      pend_blank_d = blank;
    end
    // A load in the boundary cycle wins: the flag stays set for the next frame.
    pend_flag_d = load ? 1'b1 : (frame_wrap ? 1'b0 : pend_flag_q);

    disp_dig_d   = disp_dig_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (frame_wrap && pend_flag_q) begin
      disp_dig_d   = pend_dig_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
    end

    an_on = (slot_q <= brightness) && !disp_blank_q[idx_q];
    an_d  = ~an_sel;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (an_on) begin
      seg_d = hex2seg(disp_dig_q[idx_q]);
      dp_d  = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q      <= '0;
      slot_q       <= '0;
      idx_q        <= '0;
      pend_flag_q  <= 1'b0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      disp_dig_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      pend_flag_q  <= pend_flag_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      disp_dig_q   <= disp_dig_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign SegOut     = seg_q;
  assign DpOut      = dp_q;
  assign AnOut      = an_q;
  assign frame_done = frame_done_q;

endmodule
